axis_s: RTL and testbench

AXI-Stream slave receiver, the sink end of the stream interface driven by axis_m. It accepts beats on tvalid/tready/tdata/tlast into an internal first-word-fall-through FIFO. It presents the beats to a downstream consumer over a valid/ready pair. It also keeps packet statistics: a completion pulse, a completed-packet count, the last packet length and a sticky length-error flag.

---
 rtl/axis_s_if.sv | 13 +
 rtl/axis_s.sv | 130 +++++++++++++
 tb/tb_axis_s.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_s_if.sv
// Valid/ready stream bundle with end-of-packet marker, shared by the AXIS input
// and the consumer-facing output of axis_s.
interface axis_s_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_s.sv
// AXI-Stream sink: first-word-fall-through FIFO towards a valid/ready consumer,
// plus input-side packet statistics (done pulse, count, last length, length error).
module axis_s #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             aclk,
    input  logic             areset,
    axis_s_if.slave          s_axis,
    axis_s_if.master         m_out,
    output logic             pkt_done,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] pkt_len,
    output logic             len_err
);
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FCNT_W = $clog2(DEPTH + 1);
    localparam logic [FCNT_W-1:0] DEPTH_C   = FCNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  MAX_LEN_C = CNT_W'(MAX_LEN);

    logic [DATA_W:0]     mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]   count_q, count_d;
    logic [DATA_W:0]     head;
    logic                push;
    logic                pop;

    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]    beat_inc;
    logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]    pkt_len_q, pkt_len_d;
    logic                pkt_done_q, pkt_done_d;
    logic                len_err_q, len_err_d;

    // Ready depends only on reset and registered occupancy; a pop never frees a slot
    // within the same cycle.
    assign s_axis.tready = !areset && (count_q < DEPTH_C);
    assign push          = s_axis.tvalid && s_axis.tready;

    assign m_out.tvalid  = (count_q != '0);
    assign pop           = m_out.tvalid && m_out.tready;
    assign head          = m_out.tvalid ? mem_q[rd_ptr_q] : '0;
    assign m_out.tdata   = head[DATA_W-1:0];
    assign m_out.tlast   = head[DATA_W];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; the empty gate on the head hides stale entries.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_axis.tlast, s_axis.tdata};
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign beat_inc = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + 1'b1;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        pkt_len_d  = pkt_len_q;
        len_err_d  = len_err_q;
        pkt_done_d = 1'b0;
        if (push) begin
            // Beat counter holds the beats already seen, so >= MAX_LEN means this
            // beat is past the legal length.
            if (beat_cnt_q >= MAX_LEN_C) begin
                len_err_d = 1'b1;
            end
            if (s_axis.tlast) begin
                beat_cnt_d = '0;
                pkt_len_d  = beat_inc;
                pkt_cnt_d  = pkt_cnt_q + 1'b1;
                pkt_done_d = 1'b1;
            end else begin
                beat_cnt_d = beat_inc;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            beat_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            pkt_len_q  <= '0;
            pkt_done_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            pkt_len_q  <= pkt_len_d;
            pkt_done_q <= pkt_done_d;
            len_err_q  <= len_err_d;
        end
    end

    assign pkt_done = pkt_done_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign pkt_len  = pkt_len_q;
    assign len_err  = len_err_q;
endmodule

// File: tb/tb_axis_s.sv
// Scenario bench for axis_s: a scoreboard queue filled as beats are accepted and
// drained by a monitor that checks every beat popped by the consumer.
module tb_axis_s;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned CNT_W   = 16;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    axis_s_if #(.DATA_W(DATA_W)) s_axis ();
    axis_s_if #(.DATA_W(DATA_W)) m_out ();

    logic             pkt_done;
    logic [CNT_W-1:0] pkt_cnt;
    logic [CNT_W-1:0] pkt_len;
    logic             len_err;

    axis_s #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .aclk    (aclk),
        .areset  (areset),
        .s_axis  (s_axis),
        .m_out   (m_out),
        .pkt_done(pkt_done),
        .pkt_cnt (pkt_cnt),
        .pkt_len (pkt_len),
        .len_err (len_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [DATA_W:0] sb_q[$];

    // Consumer-side monitor: a pop happens at the next rising edge.
    always @(negedge aclk) begin
        logic [DATA_W:0] exp_beat;
        if (pkt_done === 1'b1) done_cnt++;
        if (areset === 1'b0 && m_out.tvalid === 1'b1 && m_out.tready === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra: got last=%b data=%h, required no beat",
                         m_out.tlast, m_out.tdata);
            end else begin
                exp_beat = sb_q.pop_front();
                if ({m_out.tlast, m_out.tdata} !== exp_beat) begin
                    n_fail++;
                    $display("FAIL sb_beat: got last=%b data=%h, required last=%b data=%h",
                             m_out.tlast, m_out.tdata, exp_beat[DATA_W], exp_beat[DATA_W-1:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one beat, wait (bounded) for acceptance, record it; returns at edge+1.
    task automatic send_beat(input logic [DATA_W-1:0] d, input logic l);
        bit acc = 1'b0;
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = d;
        s_axis.tlast  = l;
        for (int t = 0; t < 200; t++) begin
            @(negedge aclk);
            if (s_axis.tready === 1'b1) begin
                acc = 1'b1;
                break;
            end
        end
        if (acc) begin
            sb_q.push_back({l, d});
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got tready=%b, required 1 within 200 cycles",
                     s_axis.tready);
        end
        @(posedge aclk);
        #1;
        s_axis.tvalid = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge aclk);
            #1;
            if (sb_q.size() == 0 && m_out.tvalid === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        areset        = 1'b1;
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = 32'hDEAD_BEEF;
        s_axis.tlast  = 1'b0;
        m_out.tready  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            n_checks++;
            if (s_axis.tready !== 1'b0 || m_out.tvalid !== 1'b0 || pkt_cnt !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: got tready=%b out_valid=%b pkt_cnt=%0d, required 0/0/0",
                         s_axis.tready, m_out.tvalid, pkt_cnt);
            end
        end
        @(posedge aclk);
        #1;
        n_checks++;
        if (m_out.tdata !== '0 || m_out.tlast !== 1'b0 || pkt_done !== 1'b0 ||
            pkt_len !== '0 || len_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h last=%b done=%b len=%0d err=%b, required zeros",
                     m_out.tdata, m_out.tlast, pkt_done, pkt_len, len_err);
        end
        s_axis.tvalid = 1'b0;
        areset        = 1'b0;
        @(negedge aclk);
        n_checks++;
        if (s_axis.tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_tready: got %b, required 1", s_axis.tready);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_single_packet();
        logic [CNT_W-1:0] base = pkt_cnt;
        int d0 = done_cnt;
        bit ok;
        m_out.tready  = 1'b1;
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = 32'hAAAA_BBBB;
        s_axis.tlast  = 1'b0;
        @(negedge aclk);
        n_checks++;
        if (m_out.tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_no_passthru: got out_valid=%b, required 0", m_out.tvalid);
        end
        sb_q.push_back({1'b0, 32'hAAAA_BBBB});
        @(posedge aclk);
        #1;
        s_axis.tvalid = 1'b0;
        n_checks++;
        if (m_out.tvalid !== 1'b1 || m_out.tdata !== 32'hAAAA_BBBB || m_out.tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency: got valid=%b data=%h last=%b, required 1/aaaabbbb/0",
                     m_out.tvalid, m_out.tdata, m_out.tlast);
        end
        send_beat(32'hCCCC_DDDD, 1'b1);
        n_checks++;
        if (pkt_done !== 1'b1 || pkt_cnt !== base + 16'd1 || pkt_len !== 16'd2) begin
            n_fail++;
            $display("FAIL single_stats: got done=%b cnt=%0d len=%0d, required 1/%0d/2",
                     pkt_done, pkt_cnt, pkt_len, base + 16'd1);
        end
        @(posedge aclk);
        #1;
        n_checks++;
        if (pkt_done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done_width: got %b, required 0", pkt_done);
        end
        drain(ok);
        n_checks++;
        if (!ok || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL single_drain: got drained=%b pulses=%0d, required 1/1", ok, done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        m_out.tready = 1'b0;
        for (int i = 1; i <= 4; i++) send_beat(DATA_W'(i), 1'b0);
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = 32'd5;
        s_axis.tlast  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            n_checks++;
            if (s_axis.tready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_full_tready: got %b, required 0", s_axis.tready);
            end
        end
        @(posedge aclk);
        #1;
        m_out.tready = 1'b1;
        @(negedge aclk);
        n_checks++;
        if (s_axis.tready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_pop_cycle_tready: got %b, required 0", s_axis.tready);
        end
        @(posedge aclk);
        #1;
        n_checks++;
        if (s_axis.tready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_tready_return: got %b, required 1", s_axis.tready);
        end
        send_beat(32'd5, 1'b0);
        send_beat(32'd6, 1'b1);
        drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d beats left, required 0", sb_q.size());
        end
    endtask

    task automatic test_full_push_pop();
        bit ok;
        m_out.tready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(32'h100 + DATA_W'(i), 1'b0);
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = 32'h104;
        s_axis.tlast  = 1'b1;
        m_out.tready  = 1'b1;
        @(negedge aclk);
        n_checks++;
        if (s_axis.tready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pp_tready: got %b, required 0", s_axis.tready);
        end
        @(posedge aclk);
        #1;
        m_out.tready = 1'b0;
        n_checks++;
        if (s_axis.tready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pp_next_tready: got %b, required 1", s_axis.tready);
        end
        send_beat(32'h104, 1'b1);
        n_checks++;
        if (s_axis.tready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pp_refill: got tready=%b, required 0", s_axis.tready);
        end
        m_out.tready = 1'b1;
        drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL full_pp_drain: got %0d beats left, required 0", sb_q.size());
        end
    endtask

    task automatic test_len_err();
        bit ok;
        m_out.tready = 1'b1;
        for (int i = 1; i <= 16; i++) send_beat(32'h2000 + DATA_W'(i), i == 16);
        n_checks++;
        if (len_err !== 1'b0 || pkt_len !== 16'd16) begin
            n_fail++;
            $display("FAIL len_max_legal: got err=%b len=%0d, required 0/16", len_err, pkt_len);
        end
        for (int i = 1; i <= 17; i++) begin
            send_beat(32'h3000 + DATA_W'(i), i == 17);
            if (i == 16) begin
                n_checks++;
                if (len_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL len_err_early: got %b after beat 16, required 0", len_err);
                end
            end
        end
        n_checks++;
        if (len_err !== 1'b1 || pkt_len !== 16'd17) begin
            n_fail++;
            $display("FAIL len_err_set: got err=%b len=%0d, required 1/17", len_err, pkt_len);
        end
        send_beat(32'h4000, 1'b1);
        n_checks++;
        if (len_err !== 1'b1 || pkt_len !== 16'd1) begin
            n_fail++;
            $display("FAIL len_err_sticky: got err=%b len=%0d, required 1/1", len_err, pkt_len);
        end
        drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL len_drain: got %0d beats left, required 0", sb_q.size());
        end
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        m_out.tready = 1'b0;
        send_beat(32'h5555_0001, 1'b0);
        send_beat(32'h5555_0002, 1'b0);
        @(negedge aclk);
        n_checks++;
        if (m_out.tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_prefill: got out_valid=%b, required 1", m_out.tvalid);
        end
        #2;
        areset = 1'b1;
        #1;
        n_checks++;
        if (m_out.tvalid !== 1'b0 || s_axis.tready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_drop: got out_valid=%b tready=%b, required 0/0",
                     m_out.tvalid, s_axis.tready);
        end
        sb_q.delete();
        @(posedge aclk);
        #1;
        n_checks++;
        if (pkt_cnt !== '0 || pkt_len !== '0 || len_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_clear: got cnt=%0d len=%0d err=%b, required 0/0/0",
                     pkt_cnt, pkt_len, len_err);
        end
        areset = 1'b0;
        send_beat(32'h1234_5678, 1'b1);
        n_checks++;
        if (m_out.tdata !== 32'h1234_5678 || m_out.tlast !== 1'b1 || pkt_cnt !== 16'd1 ||
            pkt_len !== 16'd1) begin
            n_fail++;
            $display("FAIL mid_new_packet: got data=%h last=%b cnt=%0d len=%0d, required 12345678/1/1/1",
                     m_out.tdata, m_out.tlast, pkt_cnt, pkt_len);
        end
        m_out.tready = 1'b1;
        drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL mid_drain: got %0d beats left, required 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_backpressure();
        test_full_push_pop();
        test_len_err();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
